// File: rtl/smt_fetch_scheduler_if.sv
// Fetch-slot bundle between the per-thread front-end request logic, the SMT
// fetch scheduler and the shared instruction-fetch unit.
interface smt_fetch_scheduler_if #(
    parameter int WEIGHT_W = 4
);
    logic                t0_req;
    logic                t1_req;
    logic                t0_stall;
    logic                t1_stall;
    logic [WEIGHT_W-1:0] weight_t0;
    logic [WEIGHT_W-1:0] weight_t1;
    logic                fetch_ready;
    logic                fetch_valid;
    logic                fetch_tid;
    logic                grant_t0;
    logic                grant_t1;
    logic                starve_boost;

    modport master (
        input  t0_req, t1_req, t0_stall, t1_stall,
        input  weight_t0, weight_t1, fetch_ready,
        output fetch_valid, fetch_tid, grant_t0, grant_t1, starve_boost
    );

    modport slave (
        output t0_req, t1_req, t0_stall, t1_stall,
        output weight_t0, weight_t1, fetch_ready,
        input  fetch_valid, fetch_tid, grant_t0, grant_t1, starve_boost
    );
endinterface

// File: rtl/smt_fetch_scheduler.sv
// Weighted round-robin fetch-slot scheduler for two SMT threads, with
// starvation override and a registered valid/ready slot toward fetch.
module smt_fetch_scheduler #(
    parameter int WEIGHT_W     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    smt_fetch_scheduler_if.master bus
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(STARVE_LIMIT);

    logic                r_fetchValid;
    logic                r_fetchTid;
    logic                r_starveBoost;
    logic                r_cur;
    logic [WEIGHT_W-1:0] r_cnt;
    logic [STARVE_W-1:0] r_wait [2];

    logic [1:0]          w_eligible;
    logic                w_other;
    logic                w_slotFree;
    logic [WEIGHT_W-1:0] w_effW0;
    logic [WEIGHT_W-1:0] w_effW1;
    logic [WEIGHT_W-1:0] w_effCur;
    logic [STARVE_W-1:0] w_waitOther;
    logic                w_nextValid;
    logic                w_nextTid;
    logic                w_nextBoost;
    logic                w_nextCur;
    logic [WEIGHT_W-1:0] w_nextCnt;
    logic [STARVE_W-1:0] w_nextWait [2];

    assign w_eligible  = {bus.t1_req & ~bus.t1_stall, bus.t0_req & ~bus.t0_stall};
    assign w_other     = ~r_cur;
    assign w_slotFree  = ~r_fetchValid | bus.fetch_ready;
    assign w_effW0     = (bus.weight_t0 == '0) ? WEIGHT_W'(1) : bus.weight_t0;
    assign w_effW1     = (bus.weight_t1 == '0) ? WEIGHT_W'(1) : bus.weight_t1;
    assign w_effCur    = r_cur ? w_effW1 : w_effW0;
    assign w_waitOther = r_wait[w_other];

    // Priority: starving other thread, current turn quota, hand-over, reuse of cur.
    always_comb begin
        w_nextValid = r_fetchValid;
        w_nextTid   = r_fetchTid;
        w_nextBoost = r_starveBoost;
        w_nextCur   = r_cur;
        w_nextCnt   = r_cnt;
        if (w_slotFree) begin
            if (w_eligible[w_other] && (w_waitOther >= LIMIT_V)) begin
                w_nextValid = 1'b1;
                w_nextTid   = w_other;
                w_nextBoost = 1'b1;
                w_nextCur   = w_other;
                w_nextCnt   = WEIGHT_W'(1);
            end else if (w_eligible[r_cur] && (r_cnt < w_effCur)) begin
                w_nextValid = 1'b1;
                w_nextTid   = r_cur;
                w_nextBoost = 1'b0;
                w_nextCnt   = r_cnt + WEIGHT_W'(1);
            end else if (w_eligible[w_other]) begin
                w_nextValid = 1'b1;
                w_nextTid   = w_other;
                w_nextBoost = 1'b0;
                w_nextCur   = w_other;
                w_nextCnt   = WEIGHT_W'(1);
            end else if (w_eligible[r_cur]) begin
                w_nextValid = 1'b1;
                w_nextTid   = r_cur;
                w_nextBoost = 1'b0;
                w_nextCnt   = WEIGHT_W'(1);
            end else begin
                w_nextValid = 1'b0;
                w_nextBoost = 1'b0;
            end
        end
    end

    // A thread's wait only grows while it is eligible and not the one being loaded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_nextWait[i] = r_wait[i];
            if (!w_eligible[i] || (w_slotFree && w_nextValid && (w_nextTid == 1'(i)))) begin
                w_nextWait[i] = '0;
            end else if (r_wait[i] < LIMIT_V) begin
                w_nextWait[i] = r_wait[i] + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchValid  <= 1'b0;
            r_fetchTid    <= 1'b0;
            r_starveBoost <= 1'b0;
            r_cur         <= 1'b0;
            r_cnt         <= '0;
            r_wait[0]     <= '0;
            r_wait[1]     <= '0;
        end else begin
            r_fetchValid  <= w_nextValid;
            r_fetchTid    <= w_nextTid;
            r_starveBoost <= w_nextBoost;
            r_cur         <= w_nextCur;
            r_cnt         <= w_nextCnt;
            r_wait[0]     <= w_nextWait[0];
            r_wait[1]     <= w_nextWait[1];
        end
    end

    assign bus.fetch_valid  = r_fetchValid;
    assign bus.fetch_tid    = r_fetchTid;
    assign bus.starve_boost = r_starveBoost;
    assign bus.grant_t0     = r_fetchValid & ~r_fetchTid;
    assign bus.grant_t1     = r_fetchValid & r_fetchTid;
endmodule

// File: tb/tb_smt_fetch_scheduler.sv
// Bench for smt_fetch_scheduler: a per-cycle reference model of the slot
// arbitration rules plus directed scenarios with literal expected grants.
module tb_smt_fetch_scheduler;
    localparam int WEIGHT_W = 4;
    localparam int LIMIT    = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    smt_fetch_scheduler_if #(.WEIGHT_W(WEIGHT_W)) bus ();

    smt_fetch_scheduler #(
        .WEIGHT_W    (WEIGHT_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the fetch slot must look like after each edge.
    int mValid = 0;
    int mTid   = 0;
    int mBoost = 0;
    int mCur   = 0;
    int mCnt   = 0;
    int mWait [2] = '{0, 0};

    task automatic modelStep();
        int elig [2];
        int weight [2];
        int loaded;
        int o;
        int quota;
        if (rst) begin
            mValid = 0; mTid = 0; mBoost = 0; mCur = 0; mCnt = 0;
            mWait[0] = 0; mWait[1] = 0;
        end else begin
            elig[0]   = (bus.t0_req && !bus.t0_stall) ? 1 : 0;
            elig[1]   = (bus.t1_req && !bus.t1_stall) ? 1 : 0;
            weight[0] = int'(bus.weight_t0);
            weight[1] = int'(bus.weight_t1);
            loaded    = -1;
            if (mValid == 0 || bus.fetch_ready) begin
                o     = 1 - mCur;
                quota = (weight[mCur] == 0) ? 1 : weight[mCur];
                if (elig[o] == 1 && mWait[o] >= LIMIT) begin
                    mValid = 1; mTid = o; mBoost = 1; mCur = o; mCnt = 1;
                end else if (elig[mCur] == 1 && mCnt < quota) begin
                    mValid = 1; mTid = mCur; mBoost = 0; mCnt = mCnt + 1;
                end else if (elig[o] == 1) begin
                    mValid = 1; mTid = o; mBoost = 0; mCur = o; mCnt = 1;
                end else if (elig[mCur] == 1) begin
                    mValid = 1; mTid = mCur; mBoost = 0; mCnt = 1;
                end else begin
                    mValid = 0; mBoost = 0;
                end
                if (mValid == 1) loaded = mTid;
            end
            for (int i = 0; i < 2; i++) begin
                if (elig[i] == 0 || loaded == i) mWait[i] = 0;
                else if (mWait[i] < LIMIT) mWait[i] = mWait[i] + 1;
            end
        end
    endtask

    // Every cycle: advance the model on the edge, compare shortly after.
    always @(posedge clk) begin
        modelStep();
        #1;
        checks++;
        if ((bus.fetch_valid !== mValid[0]) ||
            (bus.grant_t0 !== (mValid == 1 && mTid == 0)) ||
            (bus.grant_t1 !== (mValid == 1 && mTid == 1)) ||
            (mValid == 1 && (bus.fetch_tid !== mTid[0] || bus.starve_boost !== mBoost[0]))) begin
            errors++;
            $display("[TB] FAIL model t=%0t actual v=%b tid=%b boost=%b g0=%b g1=%b required v=%0d tid=%0d boost=%0d",
                     $time, bus.fetch_valid, bus.fetch_tid, bus.starve_boost,
                     bus.grant_t0, bus.grant_t1, mValid, mTid, mBoost);
        end
    end

    task automatic applyStimulus(input logic rstV, input logic r0, input logic s0,
                                 input logic r1, input logic s1,
                                 input logic [WEIGHT_W-1:0] w0, input logic [WEIGHT_W-1:0] w1,
                                 input logic rdy);
        @(negedge clk);
        rst           = rstV;
        bus.t0_req    = r0;
        bus.t0_stall  = s0;
        bus.t1_req    = r1;
        bus.t1_stall  = s1;
        bus.weight_t0 = w0;
        bus.weight_t1 = w1;
        bus.fetch_ready = rdy;
    endtask

    task automatic checkOutput(input logic expValid, input logic expTid,
                               input logic expBoost, input string name);
        logic expG0;
        logic expG1;
        @(posedge clk);
        #2;
        expG0 = expValid & ~expTid;
        expG1 = expValid & expTid;
        checks++;
        if ((bus.fetch_valid !== expValid) || (bus.grant_t0 !== expG0) || (bus.grant_t1 !== expG1) ||
            (expValid && (bus.fetch_tid !== expTid || bus.starve_boost !== expBoost))) begin
            errors++;
            $display("[TB] FAIL %s actual v=%b tid=%b boost=%b g0=%b g1=%b required v=%b tid=%b boost=%b",
                     name, bus.fetch_valid, bus.fetch_tid, bus.starve_boost,
                     bus.grant_t0, bus.grant_t1, expValid, expTid, expBoost);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput(1'b0, 1'b0, 1'b0, "reset");
    endtask

    initial begin
        logic [7:0] seqA;
        logic [9:0] seqB;
        logic [9:0] boostB;
        rst = 1'b1;
        bus.t0_req = 1'b0; bus.t1_req = 1'b0;
        bus.t0_stall = 1'b0; bus.t1_stall = 1'b0;
        bus.weight_t0 = '0; bus.weight_t1 = '0;
        bus.fetch_ready = 1'b0;

        // Weights 3/1: three T0 slots per T1 slot.
        doReset();
        seqA = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd1, 1'b1);
            checkOutput(1'b1, seqA[i], 1'b0, "wrr_3_1");
        end

        // Weights 15/1: T1 only gets in through the starvation override.
        doReset();
        seqB   = 10'b10000_10000;
        boostB = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 4'd1, 1'b1);
            checkOutput(1'b1, seqB[i], boostB[i], "starve_15_1");
        end

        // Lone T1 keeps the slot; T0 takes over once its request appears.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1);
            checkOutput(1'b1, 1'b1, 1'b0, "only_t1");
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1);
        checkOutput(1'b1, 1'b0, 1'b0, "t0_joins");

        // Backpressure: offered T0 slot is held even after T0 stalls.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
        checkOutput(1'b1, 1'b0, 1'b0, "bp_offer");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, (i >= 1), 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
            checkOutput(1'b1, 1'b0, 1'b0, "bp_hold");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput(1'b1, 1'b1, 1'b1, "bp_release");

        // Zero weights behave as one: strict alternation.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
            checkOutput(1'b1, 1'(i % 2), 1'b0, "zero_weights");
        end

        // Reset while a slot is held drops it; restart begins with T0.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
        checkOutput(1'b1, 1'b1, 1'b0, "hold_before_rst");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
        checkOutput(1'b0, 1'b0, 1'b0, "rst_mid_handshake");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput(1'b1, 1'b0, 1'b0, "after_rst_t0");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput(1'b1, 1'b1, 1'b0, "after_rst_t1");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput(1'b0, 1'b0, 1'b0, "idle");
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
